// File: rtl/logic_op_sched.sv
// Round-robin scheduler sharing one bitwise logic unit (AND/OR/NOT/XOR/XNOR/NOR/NAND) among NREQ requesters.
// Latency: request accepted in cycle T, response valid from T+2; one operation in flight, issue interval >= 3 cycles.
// Backpressure: response held stable while rsp_ready is low; no request is accepted until the response leaves.
// Optional: define LOGIC_SCHED_STATS_EN to add a saturating 16-bit op_count output of completed responses.
module logic_op_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_y,
    output logic                  rsp_err,
    output logic                  busy
`ifdef LOGIC_SCHED_STATS_EN
    ,
    output logic [15:0]           op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation captured at the grant handshake; the requester is free to change its inputs afterwards.
    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [IDW-1:0]   id;
    } hold_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    hold_t          hold;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic           accept;
    logic           rsp_done;
    logic [WIDTH:0] eval_res;

    // Shared gate unit: returns {err, y}; opcode 7 yields zero data with the error flag.
    function automatic logic [WIDTH:0] eval_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            3'd0:    r = {1'b0, a & b};
            3'd1:    r = {1'b0, a | b};
            3'd2:    r = {1'b0, ~a};
            3'd3:    r = {1'b0, a ^ b};
            3'd4:    r = {1'b0, ~(a ^ b)};
            3'd5:    r = {1'b0, ~(a | b)};
            3'd6:    r = {1'b0, ~(a & b)};
            default: r = {1'b1, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    // Rotating priority scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    // Next-state and handshake outputs; requests are only accepted in IDLE and never during reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req_ready[grant_id] = 1'b1;
                    accept              = 1'b1;
                    state_nxt           = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign busy     = (state != IDLE);
    assign eval_res = eval_op(hold.op, hold.a, hold.b);

    // Capture the granted requester's opcode and operands at the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (accept) begin
            hold.op <= req_op[3*grant_id +: 3];
            hold.a  <= req_a[WIDTH*grant_id +: WIDTH];
            hold.b  <= req_b[WIDTH*grant_id +: WIDTH];
            hold.id <= grant_id;
        end
    end

    // Response register: loaded in EXEC, held through RESP, valid dropped on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_err   <= 1'b0;
            rsp_id    <= '0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_y     <= eval_res[WIDTH-1:0];
            rsp_err   <= eval_res[WIDTH];
            rsp_id    <= hold.id;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the requester whose response was consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (rsp_done) begin
            if (hold.id == IDW'(NREQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= hold.id + 1'b1;
            end
        end
    end

`ifdef LOGIC_SCHED_STATS_EN
    // Completed-response counter, saturating so it never wraps back to a small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_done && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_op_sched.sv
module tb_logic_op_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_err;
    logic                  busy;
`ifdef LOGIC_SCHED_STATS_EN
    logic [15:0]           op_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int resp_cnt = 0;
    logic [7:0] tbl [8];

    always #5 clk = ~clk;

    logic_op_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .busy      (busy)
`ifdef LOGIC_SCHED_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3]        = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    // One isolated request with rsp_ready high; starts and ends just after a rising edge.
    task automatic run_one(input int id, input logic [2:0] op, input logic [7:0] ey, input logic ee);
        set_req(id, op, 8'hA5, 8'h0F);
        req_valid = 4'(1 << id);
        mid();
        check("grant", 32'(req_ready), 32'(1 << id));
        tick();
        req_valid = '0;
        set_req(id, 3'd0, 8'h00, 8'h00);
        mid();
        check("exec_no_valid", 32'(rsp_valid), 32'd0);
        tick();
        mid();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_y", 32'(rsp_y), 32'(ey));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        tick();
        resp_cnt++;
    endtask

    initial begin
        tbl = '{8'h05, 8'hAF, 8'h5A, 8'hAA, 8'h55, 8'h50, 8'hFA, 8'h00};
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mid();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef LOGIC_SCHED_STATS_EN
        check("rst_op_count", 32'(op_count), 32'd0);
`endif
        tick();

        // Single XOR from requester 2.
        run_one(2, 3'd3, 8'hAA, 1'b0);

        // Opcode sweep across requesters.
        for (int k = 0; k < 7; k++) begin
            run_one(k % 4, 3'(k), tbl[k], 1'b0);
        end

        // Illegal opcode from requester 1.
        run_one(1, 3'd7, 8'h00, 1'b1);
`ifdef LOGIC_SCHED_STATS_EN
        check("op_count", 32'(op_count), 32'(resp_cnt));
`endif

        // Backpressure: NAND from requester 2, response stalled for 5 cycles.
        rsp_ready = 1'b0;
        set_req(2, 3'd6, 8'hA5, 8'h0F);
        req_valid = 4'b0100;
        mid();
        check("bp_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b1011;
        tick();
        mid();
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_y", 32'(rsp_y), 32'hFA);
        for (int c = 0; c < 5; c++) begin
            tick();
            mid();
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_y", 32'(rsp_y), 32'hFA);
            check("bp_hold_id", 32'(rsp_id), 32'd2);
            check("bp_no_ready", 32'(req_ready), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        req_valid = '0;
        mid();
        check("bp_still_valid", 32'(rsp_valid), 32'd1);
        tick();
        resp_cnt++;
        mid();
        check("bp_released", 32'(rsp_valid), 32'd0);
        check("bp_idle", 32'(busy), 32'd0);
        tick();

        // Reset while a response is pending; the response is dropped.
        rsp_ready = 1'b0;
        set_req(1, 3'd1, 8'hA5, 8'h0F);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        mid();
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mid();
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();

        // Round robin with every requester valid: grants 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 3'(i), 8'hA5, 8'h0F);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            mid();
            check("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
            tick();
            mid();
            check("rr_exec_ready", 32'(req_ready), 32'd0);
            check("rr_busy", 32'(busy), 32'd1);
            tick();
            mid();
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_rsp_id", 32'(rsp_id), 32'(g % 4));
            check("rr_rsp_y", 32'(rsp_y), 32'(tbl[g % 4]));
            tick();
        end
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
